usb_ep_bank: RTL

Parametrised endpoint bank that sits between the USB transaction engine and application logic. It serves up to 16 endpoints. Each endpoint has its own packet buffers, data-toggle state and stall state. The block drives the engine's per-transaction handshake and toggle inputs, buffers OUT/SETUP payloads and sources IN payloads.

---
 rtl/usb_ep_bank.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_ep_bank.sv
// usb_ep_bank: endpoint bank between the USB transaction engine and the application.
// Holds per-endpoint OUT/IN packet buffers, data-toggle and stall state. It drives the
// engine's handshake and toggle for each token, captures OUT/SETUP payloads and sources IN payloads.
//
// Ports:
//   clk_48, rst (sync, active-high), usb_rst (bus reset, same effect as rst)
//   engine : transaction_active, endpoint, direction_in, setup, data_out, data_strobe,
//            success -> handshake, data_toggle, data_in, data_in_valid
//   app    : app_ep, app_rd_addr, app_out_release, app_wr, app_wr_data, app_in_commit,
//            app_stall_set, app_stall_clr -> app_out_len, app_out_setup, app_rd_data
//   status : out_full, in_busy (one bit per endpoint)
//
// Build option: define USB_EP_CTRL0_ONLY_EN to restrict SETUP to endpoint 0. A SETUP token
// to any other endpoint is then answered with stall and is never committed.
module usb_ep_bank #(
  parameter int unsigned EP_COUNT  = 4,
  parameter int unsigned PKT_BYTES = 64,
  localparam int unsigned PKT_AW   = $clog2(PKT_BYTES)
) (
  input  logic                clk_48,
  input  logic                rst,
  input  logic                usb_rst,
  input  logic                transaction_active,
  input  logic [3:0]          endpoint,
  input  logic                direction_in,
  input  logic                setup,
  output logic                data_toggle,
  output logic [1:0]          handshake,
  input  logic [7:0]          data_out,
  output logic [7:0]          data_in,
  output logic                data_in_valid,
  input  logic                data_strobe,
  input  logic                success,
  input  logic [3:0]          app_ep,
  output logic [PKT_AW:0]     app_out_len,
  output logic                app_out_setup,
  input  logic [PKT_AW-1:0]   app_rd_addr,
  output logic [7:0]          app_rd_data,
  input  logic                app_out_release,
  input  logic                app_wr,
  input  logic [7:0]          app_wr_data,
  input  logic                app_in_commit,
  input  logic                app_stall_set,
  input  logic                app_stall_clr,
  output logic [EP_COUNT-1:0] out_full,
  output logic [EP_COUNT-1:0] in_busy
);

  localparam int unsigned LW    = PKT_AW + 1;
  localparam int unsigned EPW   = (EP_COUNT > 1) ? $clog2(EP_COUNT) : 1;
  localparam int unsigned EPN   = 1 << EPW;
  localparam int unsigned MAW   = EPW + PKT_AW;
  localparam int unsigned DEPTH = 1 << MAW;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NONE  = 2'b01;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  typedef enum logic [1:0] {IDLE, OUT_RX, IN_TX, WAIT_END} state_e;

  state_e           state_q;
  logic             ta_q;
  logic [EPW-1:0]   ep_q;
  logic             setup_q;
  logic [LW-1:0]    ptr_q;
  logic [1:0]       hs_q;
  logic             tog_q;
  logic [7:0]       app_rd_data_q;

  logic [EPN-1:0]   out_full_q, in_busy_q, stall_q, out_tog_q, in_tog_q, out_setup_q;
  logic [LW-1:0]    out_len_q  [EPN];
  logic [LW-1:0]    in_len_q   [EPN];
  logic [LW-1:0]    in_fill_q  [EPN];

  logic [7:0]       in_mem  [DEPTH];
  logic [7:0]       out_mem [DEPTH];

  // Token decode for the endpoint being latched.
  logic             tok_rise, tok_valid;
  logic [EPW-1:0]   tok_idx;
  logic [1:0]       tok_hs;
  logic             tok_tog;
  logic             tok_in;

  // App-side decode.
  logic             app_valid;
  logic [EPW-1:0]   app_idx;

  logic             xfer_ok, out_we, in_we, any_rst;
  logic [MAW-1:0]   out_waddr, in_waddr;

  assign any_rst   = rst | usb_rst;
  assign tok_rise  = transaction_active & ~ta_q;
  assign tok_idx   = endpoint[EPW-1:0];
  assign tok_valid = ({1'b0, endpoint} < 5'(EP_COUNT));
  assign tok_in    = direction_in & ~setup;
  assign app_idx   = app_ep[EPW-1:0];
  assign app_valid = ({1'b0, app_ep} < 5'(EP_COUNT));
  assign xfer_ok   = (hs_q == HS_ACK);

  // Handshake/toggle decision, frozen into hs_q/tog_q at the token so it stays stable.
  always_comb begin
    tok_hs  = HS_NONE;
    tok_tog = 1'b0;
    if (!tok_valid) begin
      tok_hs = HS_NONE;
`ifdef USB_EP_CTRL0_ONLY_EN
    end else if (setup && (endpoint != 4'd0)) begin
      tok_hs = HS_STALL;
`endif
    end else if (setup) begin
      tok_hs = HS_ACK;
    end else if (stall_q[tok_idx]) begin
      tok_hs = HS_STALL;
    end else if (!direction_in) begin
      tok_hs = out_full_q[tok_idx] ? HS_NAK : HS_ACK;
    end else begin
      tok_hs = in_busy_q[tok_idx] ? HS_ACK : HS_NAK;
    end
    if (setup)             tok_tog = 1'b0;
    else if (direction_in) tok_tog = in_tog_q[tok_idx];
    else                   tok_tog = out_tog_q[tok_idx];
  end

  // Buffer write ports; OUT bytes past the buffer end are dropped by the pointer top bit.
  assign out_we    = ~any_rst & (state_q == OUT_RX) & xfer_ok & data_strobe & ~ptr_q[PKT_AW];
  assign out_waddr = {ep_q, ptr_q[PKT_AW-1:0]};
  assign in_we     = ~any_rst & app_wr & app_valid & ~in_busy_q[app_idx]
                     & ~in_fill_q[app_idx][PKT_AW];
  assign in_waddr  = {app_idx, in_fill_q[app_idx][PKT_AW-1:0]};

  always_ff @(posedge clk_48) begin
    if (out_we) out_mem[out_waddr] <= data_out;
    if (in_we)  in_mem[in_waddr]   <= app_wr_data;
  end

  // Control state; engine updates come after app updates so they win on a collision.
  always_ff @(posedge clk_48) begin
    if (any_rst) begin
      state_q       <= IDLE;
      ta_q          <= transaction_active;
      ep_q          <= '0;
      setup_q       <= 1'b0;
      ptr_q         <= '0;
      hs_q          <= HS_NONE;
      tog_q         <= 1'b0;
      app_rd_data_q <= 8'h00;
      out_full_q    <= '0;
      in_busy_q     <= '0;
      stall_q       <= '0;
      out_tog_q     <= '0;
      in_tog_q      <= '0;
      out_setup_q   <= '0;
      for (int unsigned i = 0; i < EPN; i++) begin
        out_len_q[i] <= '0;
        in_len_q[i]  <= '0;
        in_fill_q[i] <= '0;
      end
    end else begin
      ta_q          <= transaction_active;
      app_rd_data_q <= app_valid ? out_mem[{app_idx, app_rd_addr}] : 8'h00;

      if (app_valid) begin
        if (in_we) in_fill_q[app_idx] <= in_fill_q[app_idx] + LW'(1);
        if (app_in_commit && !in_busy_q[app_idx]) begin
          in_busy_q[app_idx] <= 1'b1;
          in_len_q[app_idx]  <= in_fill_q[app_idx];
          in_fill_q[app_idx] <= '0;
        end
        if (app_out_release) begin
          out_full_q[app_idx] <= 1'b0;
          out_len_q[app_idx]  <= '0;
        end
        if (app_stall_clr) stall_q[app_idx] <= 1'b0;
        if (app_stall_set) stall_q[app_idx] <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (tok_rise) begin
            ep_q    <= tok_idx;
            setup_q <= setup;
            ptr_q   <= '0;
            hs_q    <= tok_hs;
            tog_q   <= tok_tog;
            state_q <= tok_in ? IN_TX : OUT_RX;
          end else if (transaction_active) begin
            hs_q    <= HS_NAK;
            state_q <= WAIT_END;
          end
        end
        OUT_RX: begin
          if (data_strobe && !ptr_q[PKT_AW]) ptr_q <= ptr_q + LW'(1);
          if (success && xfer_ok) begin
            out_full_q[ep_q]  <= 1'b1;
            out_len_q[ep_q]   <= ptr_q;
            out_setup_q[ep_q] <= setup_q;
            if (setup_q) begin
              out_tog_q[ep_q] <= 1'b1;
              in_tog_q[ep_q]  <= 1'b1;
              stall_q[ep_q]   <= 1'b0;
              in_busy_q[ep_q] <= 1'b0;
            end else begin
              out_tog_q[ep_q] <= ~out_tog_q[ep_q];
            end
          end
          if (success || !transaction_active) begin
            hs_q    <= HS_NONE;
            tog_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        IN_TX: begin
          if (data_strobe && !ptr_q[PKT_AW]) ptr_q <= ptr_q + LW'(1);
          if (success && xfer_ok) begin
            in_busy_q[ep_q] <= 1'b0;
            in_tog_q[ep_q]  <= ~in_tog_q[ep_q];
          end
          if (success || !transaction_active) begin
            hs_q    <= HS_NONE;
            tog_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        WAIT_END: begin
          if (!transaction_active) begin
            hs_q    <= HS_NONE;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign handshake     = hs_q;
  assign data_toggle   = tog_q;
  assign data_in       = in_mem[{ep_q, ptr_q[PKT_AW-1:0]}];
  assign data_in_valid = (state_q == IN_TX) & xfer_ok & (ptr_q < in_len_q[ep_q]);
  assign app_out_len   = app_valid ? out_len_q[app_idx] : '0;
  assign app_out_setup = app_valid ? out_setup_q[app_idx] : 1'b0;
  assign app_rd_data   = app_rd_data_q;
  assign out_full      = out_full_q[EP_COUNT-1:0];
  assign in_busy       = in_busy_q[EP_COUNT-1:0];

endmodule
